// File: rtl/sevenseg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_pkg
// Description : Shared seven-segment definitions. Segment vectors are ordered
//               {g,f,e,d,c,b,a}. SEG_HEX holds the active-high hex glyphs.
//               SEG_OFF is the active-low pattern with every segment dark.
// Revision    : 1.0 - initial release
// ============================================================================
package sevenseg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h7F;

    // Active-high glyphs for 0-9, A, b, C, d, E, F
    localparam seg_t SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage
`default_nettype wire

// File: rtl/sevenseg_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_scanner_if
// Description : Bundle between the datapath and the display scanner.
//               master : the datapath side. It drives digits, dp_in,
//                        digit_en and blank, and observes the pin outputs.
//               slave  : the scanner. It consumes those inputs and drives
//                        seg_n, dp_n, an_n and slot_idx.
// Revision    : 1.0 - initial release
// ============================================================================
interface sevenseg_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    import sevenseg_pkg::*;

    logic [4*NUM_DIGITS-1:0]       digits;
    logic [NUM_DIGITS-1:0]         dp_in;
    logic [NUM_DIGITS-1:0]         digit_en;
    logic                          blank;
    seg_t                          seg_n;
    logic                          dp_n;
    logic [NUM_DIGITS-1:0]         an_n;
    logic [$clog2(NUM_DIGITS)-1:0] slot_idx;

    modport master (
        output digits, dp_in, digit_en, blank,
        input  seg_n, dp_n, an_n, slot_idx
    );

    modport slave (
        input  digits, dp_in, digit_en, blank,
        output seg_n, dp_n, an_n, slot_idx
    );

endinterface
`default_nettype wire

// File: rtl/sevenseg_scanner_hex_to_7seg.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_7seg
// Description : Combinational hex nibble to active-high {g..a} segment decode.
//   nibble : in  4  value 0-F
//   seg    : out 7  active-high segments {g,f,e,d,c,b,a}
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_7seg
    import sevenseg_pkg::*;
(
    input  wire logic [3:0] nibble,
    output seg_t            seg
);

    assign seg = SEG_HEX[nibble];

endmodule
`default_nettype wire

// File: rtl/sevenseg_scanner.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_scanner
// Description : Time-multiplexed common-anode seven-segment scanner. It steps
//               round-robin through the digits, with REFRESH_DIV cycles per
//               slot. The first BLANK_CYCLES cycles of each slot keep all
//               anodes off so that segment changes never show as ghosts.
//   clock : in  1   system clock, rising edge
//   reset : in  1   synchronous active-high reset
//   bus   : slave modport carrying digits/dp_in/digit_en/blank in and
//           seg_n/dp_n/an_n/slot_idx out. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module sevenseg_scanner
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
)(
    input  wire logic         clock,
    input  wire logic         reset,
    sevenseg_scanner_if.slave bus
);

    localparam int c_IDX_W = $clog2(NUM_DIGITS);
    localparam int c_CNT_W = $clog2(REFRESH_DIV);

    localparam logic [c_CNT_W-1:0]    c_CNT_LAST = c_CNT_W'(REFRESH_DIV - 1);
    localparam logic [c_CNT_W-1:0]    c_BLANK    = c_CNT_W'(BLANK_CYCLES);
    localparam logic [c_IDX_W-1:0]    c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_AN_OFF   = '1;

    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_IDX_W-1:0]    r_idx;
    logic [3:0]            r_nib;
    logic                  r_dp;
    logic                  r_first;

    seg_t                  r_seg_n;
    logic                  r_dp_n;
    logic [NUM_DIGITS-1:0] r_an_n;
    logic [c_IDX_W-1:0]    r_slot_idx;

    logic                  w_last;
    logic [c_IDX_W-1:0]    w_idx_next;
    logic [c_IDX_W-1:0]    w_load_idx;
    logic                  w_load;
    logic                  w_an_off;
    seg_t                  w_seg;

    assign w_last     = (r_cnt == c_CNT_LAST);
    assign w_idx_next = (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);

    // Digit data is captured on the slot-change edge for the upcoming slot.
    // On the first cycle after reset, slot 0 is captured as well, so that
    // slot 0 shows live input rather than the reset nibble.
    assign w_load_idx = w_last ? w_idx_next : r_idx;
    assign w_load     = w_last || r_first;

    assign w_an_off = (r_cnt < c_BLANK) || bus.blank || !bus.digit_en[r_idx];

    hex_to_7seg u_hex (
        .nibble (r_nib),
        .seg    (w_seg)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_nib      <= '0;
            r_dp       <= 1'b0;
            r_first    <= 1'b1;
            r_seg_n    <= SEG_OFF;
            r_dp_n     <= 1'b1;
            r_an_n     <= c_AN_OFF;
            r_slot_idx <= '0;
        end else begin
            r_first <= 1'b0;
            if (w_last) begin
                r_cnt <= '0;
                r_idx <= w_idx_next;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            if (w_load) begin
                r_nib <= bus.digits[{w_load_idx, 2'b00} +: 4];
                r_dp  <= bus.dp_in[w_load_idx];
            end

            r_seg_n    <= ~w_seg;
            r_dp_n     <= ~r_dp;
            r_slot_idx <= r_idx;
            r_an_n     <= w_an_off ? c_AN_OFF
                                   : ~(NUM_DIGITS'(1) << r_idx);
        end
    end

    assign bus.seg_n    = r_seg_n;
    assign bus.dp_n     = r_dp_n;
    assign bus.an_n     = r_an_n;
    assign bus.slot_idx = r_slot_idx;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_sevenseg_scanner
// Description : Directed self-checking bench for sevenseg_scanner with
//               NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2. Edge k counts
//               rising edges after reset release, starting at 0. The outputs
//               after edge k reflect slot (k/8)%4 at phase k%8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sevenseg_scanner;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int checks   = 0;
    int failures = 0;

    logic [6:0] hex_tbl [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    sevenseg_scanner_if #(.NUM_DIGITS(ND)) bus ();

    sevenseg_scanner #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Expected anode vector after edge k
    function automatic logic [3:0] exp_an(input int k, input logic [3:0] en,
                                          input logic blk);
        int s;
        int c;
        s = (k / RD) % ND;
        c = k % RD;
        if (c < BC || blk || !en[s]) return 4'hF;
        return ~(4'b0001 << s);
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] d, input int k);
        int s;
        s = (k / RD) % ND;
        return ~hex_tbl[d[4*s +: 4]];
    endfunction

    task automatic do_reset(input logic [15:0] d, input logic [3:0] dp,
                            input logic [3:0] en);
        bus.digits   = d;
        bus.dp_in    = dp;
        bus.digit_en = en;
        bus.blank    = 1'b0;
        reset        = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset;
        bus.digits   = 16'h1234;
        bus.dp_in    = 4'h0;
        bus.digit_en = 4'hF;
        bus.blank    = 1'b0;
        reset        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            checks++;
            if (bus.seg_n !== 7'h7F || bus.an_n !== 4'hF || bus.dp_n !== 1'b1 ||
                bus.slot_idx !== 2'd0) begin
                failures++;
                $display("FAIL reset_state cyc=%0d got seg_n=%h an_n=%h dp_n=%b slot=%0d want 7f f 1 0",
                         i, bus.seg_n, bus.an_n, bus.dp_n, bus.slot_idx);
            end
        end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            checks++;
            if (bus.an_n !== exp_an(k, 4'hF, 1'b0)) begin
                failures++;
                $display("FAIL reset_release_an k=%0d got %h want %h", k, bus.an_n,
                         exp_an(k, 4'hF, 1'b0));
            end
        end
        checks++;
        if (bus.seg_n !== ~7'h66) begin
            failures++;
            $display("FAIL first_slot_seg got %h want %h", bus.seg_n, ~7'h66);
        end
    endtask

    task automatic test_free_run;
        do_reset(16'h1234, 4'h0, 4'hF);
        for (int k = 0; k < 2 * ND * RD; k++) begin
            @(posedge clock); #1;
            checks++;
            if (bus.an_n !== exp_an(k, 4'hF, 1'b0)) begin
                failures++;
                $display("FAIL run_an k=%0d got %h want %h", k, bus.an_n, exp_an(k, 4'hF, 1'b0));
            end
            checks++;
            if (bus.slot_idx !== 2'((k / RD) % ND)) begin
                failures++;
                $display("FAIL run_slot k=%0d got %0d want %0d", k, bus.slot_idx, (k / RD) % ND);
            end
            if (k >= 1) begin
                checks++;
                if (bus.seg_n !== exp_seg(16'h1234, k)) begin
                    failures++;
                    $display("FAIL run_seg k=%0d got %h want %h", k, bus.seg_n, exp_seg(16'h1234, k));
                end
            end
        end
    endtask

    task automatic test_mid_change;
        logic [6:0] want;
        do_reset(16'h0000, 4'h0, 4'hF);
        for (int k = 0; k < 3 * RD; k++) begin
            @(posedge clock); #1;
            want = (k < 2 * RD) ? ~7'h3F : ~7'h71;
            if (k >= 1) begin
                checks++;
                if (bus.seg_n !== want) begin
                    failures++;
                    $display("FAIL midchange_seg k=%0d got %h want %h", k, bus.seg_n, want);
                end
            end
            if (k == 10) bus.digits = 16'hFFFF;
        end
    endtask

    task automatic test_enable;
        logic [3:0] en;
        logic [3:0] dp;
        en = 4'b1011;
        dp = 4'b0100;
        do_reset(16'h1234, dp, en);
        for (int k = 0; k < ND * RD; k++) begin
            @(posedge clock); #1;
            checks++;
            if (bus.an_n !== exp_an(k, en, 1'b0)) begin
                failures++;
                $display("FAIL enable_an k=%0d got %h want %h", k, bus.an_n, exp_an(k, en, 1'b0));
            end
            if (k >= 1) begin
                checks++;
                if (bus.dp_n !== ~dp[(k / RD) % ND]) begin
                    failures++;
                    $display("FAIL enable_dp k=%0d got %b want %b", k, bus.dp_n, ~dp[(k / RD) % ND]);
                end
            end
            checks++;
            if (bus.an_n !== 4'hF && bus.dp_n !== 1'b1) begin
                failures++;
                $display("FAIL enable_dp_lit k=%0d an_n=%h dp_n=%b want dp_n 1", k, bus.an_n, bus.dp_n);
            end
        end
    endtask

    task automatic test_blank;
        logic blk;
        do_reset(16'h1234, 4'h0, 4'hF);
        for (int k = 0; k < 5 * RD; k++) begin
            @(posedge clock); #1;
            blk = (k >= 28 && k <= 30);
            checks++;
            if (bus.an_n !== exp_an(k, 4'hF, blk)) begin
                failures++;
                $display("FAIL blank_an k=%0d got %h want %h", k, bus.an_n, exp_an(k, 4'hF, blk));
            end
            checks++;
            if (bus.slot_idx !== 2'((k / RD) % ND)) begin
                failures++;
                $display("FAIL blank_slot k=%0d got %0d want %0d", k, bus.slot_idx, (k / RD) % ND);
            end
            bus.blank = (k >= 27 && k <= 29);
        end
        bus.blank = 1'b0;
    endtask

    task automatic test_reset_mid(input int stop_k);
        // stop_k is the edge on which reset is sampled
        do_reset(16'h1234, 4'h0, 4'hF);
        for (int k = 0; k < stop_k; k++) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (bus.an_n !== 4'hF || bus.slot_idx !== 2'd0 || bus.seg_n !== 7'h7F ||
            bus.dp_n !== 1'b1) begin
            failures++;
            $display("FAIL midreset_state at=%0d got an_n=%h slot=%0d seg_n=%h dp_n=%b want f 0 7f 1",
                     stop_k, bus.an_n, bus.slot_idx, bus.seg_n, bus.dp_n);
        end
        reset = 1'b0;
        for (int k = 0; k <= RD; k++) begin
            @(posedge clock); #1;
            checks++;
            if (bus.an_n !== exp_an(k, 4'hF, 1'b0) || bus.slot_idx !== 2'((k / RD) % ND)) begin
                failures++;
                $display("FAIL midreset_restart at=%0d k=%0d got an_n=%h slot=%0d want %h %0d",
                         stop_k, k, bus.an_n, bus.slot_idx, exp_an(k, 4'hF, 1'b0), (k / RD) % ND);
            end
            if (k >= 1) begin
                checks++;
                if (bus.seg_n !== exp_seg(16'h1234, k)) begin
                    failures++;
                    $display("FAIL midreset_seg at=%0d k=%0d got %h want %h",
                             stop_k, k, bus.seg_n, exp_seg(16'h1234, k));
                end
            end
        end
    endtask

    initial begin
        bus.digits   = 16'h0000;
        bus.dp_in    = 4'h0;
        bus.digit_en = 4'hF;
        bus.blank    = 1'b0;
        test_reset();
        test_free_run();
        test_mid_change();
        test_enable();
        test_blank();
        test_reset_mid(21);  // cnt=5 of slot 2
        test_reset_mid(31);  // reset coincides with the slot 3 terminal count
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
